// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: exception entry/return bookkeeping, Count/Compare
// timer, mtc0/mfc0 access and the flush/redirect feed to fetch.
module cp0_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] data_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o,
  output logic        flush_o,
  output logic [31:0] newpc_o
);

  localparam logic [31:0] PRID         = 32'h0000_4220;
  localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_BP   = 32'h9;
  localparam logic [31:0] EXC_RI   = 32'hA;
  localparam logic [31:0] EXC_OV   = 32'hC;
  localparam logic [31:0] EXC_ERET = 32'hE;

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        timer_int_q, timer_int_d;
  logic        tick_q, tick_d;

  logic exc_take;
  logic is_eret;

  always_comb begin
    exc_take = 1'b0;
    case (excepttype_i)
      EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS,
      EXC_BP, EXC_RI, EXC_OV: exc_take = 1'b1;
      default:                exc_take = 1'b0;
    endcase
  end

  assign is_eret = (excepttype_i == EXC_ERET);

  always_comb begin
    // NOTE: every _d takes its _q value first so no path leaves it unassigned (no latch).
    status_d    = status_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    compare_d   = compare_q;
    badvaddr_d  = badvaddr_q;
    tick_d      = ~tick_q;
    count_d     = tick_q ? count_q + 32'd1 : count_q;
    timer_int_d = timer_int_q | ((compare_q != 32'd0) && (count_q == compare_q));

    if (we_i) begin
      case (waddr_i)
        REG_COUNT:   count_d   = data_i;
        REG_COMPARE: begin
          compare_d   = data_i;
          timer_int_d = 1'b0;
        end
        REG_STATUS:  status_d  = (status_q & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
        REG_CAUSE:   cause_d   = (cause_q & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
        REG_EPC:     epc_d     = data_i;
        default:     ;
      endcase
    end

    cause_d[15:10] = {int_i[5] | timer_int_q, int_i[4:0]};

    // Exception/eret fields are applied last so they override an mtc0 to the same field.
    if (exc_take) begin
      if (!status_q[1]) begin
        epc_d     = in_delayslot_i ? pc_i - 32'd4 : pc_i;
        cause_d[31] = in_delayslot_i;
      end
      status_d[1]  = 1'b1;
      cause_d[6:2] = (excepttype_i == EXC_INT) ? 5'd0 : excepttype_i[4:0];
      if (excepttype_i == EXC_ADEL || excepttype_i == EXC_ADES)
        badvaddr_d = bad_addr_i;
    end else if (is_eret) begin
      status_d[1] = 1'b0;
    end

    // NOTE: reset is synchronous, so it is folded into the next-state logic with top priority.
    if (rst) begin
      status_d    = STATUS_RESET;
      cause_d     = 32'd0;
      epc_d       = 32'd0;
      count_d     = 32'd0;
      compare_d   = 32'd0;
      badvaddr_d  = 32'd0;
      timer_int_d = 1'b0;
      tick_d      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    status_q    <= status_d;
    cause_q     <= cause_d;
    epc_q       <= epc_d;
    count_q     <= count_d;
    compare_q   <= compare_d;
    badvaddr_q  <= badvaddr_d;
    timer_int_q <= timer_int_d;
    tick_q      <= tick_d;
  end

  always_comb begin
    data_o = 32'd0;
    case (raddr_i)
      REG_BADVADDR: data_o = badvaddr_q;
      REG_COUNT:    data_o = count_q;
      REG_COMPARE:  data_o = compare_q;
      REG_STATUS:   data_o = status_q;
      REG_CAUSE:    data_o = cause_q;
      REG_EPC:      data_o = epc_q;
      REG_PRID:     data_o = PRID;
      default:      data_o = 32'd0;
    endcase
  end

  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign badvaddr_o  = badvaddr_q;
  assign timer_int_o = timer_int_q;
  assign flush_o     = (excepttype_i != 32'd0);
  assign newpc_o     = is_eret ? epc_q : EXC_VECTOR;

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: expectations are queued when stimulus is
// applied and popped/compared once the DUT outputs are sampled.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i, raddr_i;
  logic [31:0] data_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i, pc_i, bad_addr_i;
  logic        in_delayslot_i;
  logic [31:0] data_o, status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o, newpc_o;
  logic        timer_int_o, flush_o;

  cp0_regfile dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
    .data_i(data_i), .int_i(int_i), .excepttype_i(excepttype_i), .pc_i(pc_i),
    .in_delayslot_i(in_delayslot_i), .bad_addr_i(bad_addr_i), .data_o(data_o),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .count_o(count_o),
    .compare_o(compare_o), .badvaddr_o(badvaddr_o), .timer_int_o(timer_int_o),
    .flush_o(flush_o), .newpc_o(newpc_o)
  );

  always #5 clk = ~clk;

  typedef enum logic [3:0] {
    S_DATA, S_STATUS, S_CAUSE, S_EPC, S_COUNT, S_COMPARE, S_BADV, S_TIMER, S_FLUSH, S_NEWPC
  } sig_e;

  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference Count model kept by the bench
  logic [31:0] m_count;
  logic        m_tick;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input sig_e sig, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] observe(input sig_e sig);
    case (sig)
      S_DATA:    return data_o;
      S_STATUS:  return status_o;
      S_CAUSE:   return cause_o;
      S_EPC:     return epc_o;
      S_COUNT:   return count_o;
      S_COMPARE: return compare_o;
      S_BADV:    return badvaddr_o;
      S_TIMER:   return {31'd0, timer_int_o};
      S_FLUSH:   return {31'd0, flush_o};
      default:   return newpc_o;
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic tick();
    if (rst) begin
      m_count = 32'd0;
      m_tick  = 1'b0;
    end else begin
      if (we_i && waddr_i == 5'd9) m_count = data_i;
      else if (m_tick)             m_count = m_count + 32'd1;
      m_tick = ~m_tick;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_i = 1'b0; excepttype_i = 32'd0; in_delayslot_i = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; data_i = d;
  endtask

  task automatic exc(input logic [31:0] t, input logic [31:0] pc, input logic ds, input logic [31:0] ba);
    excepttype_i = t; pc_i = pc; in_delayslot_i = ds; bad_addr_i = ba;
  endtask

  initial begin
    rst = 1'b1; we_i = 1'b0; waddr_i = '0; raddr_i = '0; data_i = '0; int_i = '0;
    excepttype_i = '0; pc_i = '0; in_delayslot_i = 1'b0; bad_addr_i = '0;
    m_count = '0; m_tick = 1'b0;
    @(posedge clk); #1;
    tick(); tick();
    rst = 1'b0;
    expect_val("rst_status", S_STATUS, 32'h0040_0000);
    expect_val("rst_cause", S_CAUSE, 32'd0);
    expect_val("rst_count", S_COUNT, 32'd0);
    expect_val("rst_timer", S_TIMER, 32'd0);
    expect_val("rst_epc", S_EPC, 32'd0);
    drain();

    // Idle 10 cycles: Count advances once per two cycles
    for (int i = 0; i < 10; i++) tick();
    expect_val("idle_count5", S_COUNT, 32'd5);
    expect_val("idle_count_model", S_COUNT, m_count);
    expect_val("idle_status", S_STATUS, 32'h0040_0000);
    expect_val("idle_cause", S_CAUSE, 32'd0);
    expect_val("idle_flush", S_FLUSH, 32'd0);
    raddr_i = 5'd15;
    expect_val("read_prid", S_DATA, 32'h0000_4220);
    drain();
    raddr_i = 5'd3;
    expect_val("read_unmapped", S_DATA, 32'd0);
    drain();

    // Timer: Compare = 6 with Count from 0
    rst = 1'b1; tick(); rst = 1'b0;
    mtc0(5'd11, 32'd6); tick(); idle();
    begin
      int n;
      n = 0;
      while (count_o != 32'd6 && n < 40) begin tick(); n++; end
      check("count_reach_6", count_o, 32'd6);
    end
    expect_val("timer_not_yet", S_TIMER, 32'd0);
    drain();
    tick();
    expect_val("timer_rise", S_TIMER, 32'd1);
    expect_val("cause15_lag", S_CAUSE, 32'd0);
    drain();
    tick(); tick(); tick();
    expect_val("timer_sticky", S_TIMER, 32'd1);
    expect_val("cause15_set", S_CAUSE, 32'h0000_8000);
    drain();
    mtc0(5'd11, 32'd0); raddr_i = 5'd11;
    expect_val("mfc0_no_bypass", S_DATA, 32'd6);
    drain();
    tick(); idle();
    expect_val("timer_clear", S_TIMER, 32'd0);
    expect_val("compare_zero", S_COMPARE, 32'd0);
    drain();
    tick();
    expect_val("cause15_clear", S_CAUSE, 32'd0);
    drain();

    // AdEL in a delay slot
    exc(32'h4, 32'h8000_0104, 1'b1, 32'h1003);
    expect_val("adel_flush", S_FLUSH, 32'd1);
    expect_val("adel_newpc", S_NEWPC, 32'hBFC0_0380);
    drain();
    tick(); idle();
    expect_val("adel_epc", S_EPC, 32'h8000_0100);
    expect_val("adel_cause", S_CAUSE, 32'h8000_0010);
    expect_val("adel_badv", S_BADV, 32'h0000_1003);
    expect_val("adel_status", S_STATUS, 32'h0040_0002);
    raddr_i = 5'd8;
    expect_val("read_badv", S_DATA, 32'h0000_1003);
    drain();

    // Overflow while EXL = 1
    exc(32'hC, 32'h8000_0200, 1'b0, 32'h5555);
    tick(); idle();
    expect_val("ov_epc_hold", S_EPC, 32'h8000_0100);
    expect_val("ov_cause", S_CAUSE, 32'h8000_0030);
    expect_val("ov_badv_hold", S_BADV, 32'h0000_1003);
    drain();

    // Eret with a same-cycle mtc0 to EPC: redirect uses the old EPC
    exc(32'hE, 32'h0, 1'b0, 32'h0); mtc0(5'd14, 32'h1234_5678);
    expect_val("eret_flush", S_FLUSH, 32'd1);
    expect_val("eret_newpc", S_NEWPC, 32'h8000_0100);
    drain();
    tick(); idle();
    expect_val("eret_status", S_STATUS, 32'h0040_0000);
    expect_val("eret_epc_write", S_EPC, 32'h1234_5678);
    expect_val("eret_cause", S_CAUSE, 32'h8000_0030);
    drain();

    // mtc0 Status all-ones with a syscall in the same cycle
    exc(32'h8, 32'h8000_0300, 1'b0, 32'h0); mtc0(5'd12, 32'hFFFF_FFFF);
    tick(); idle();
    expect_val("sys_status", S_STATUS, 32'h0040_FF03);
    expect_val("sys_cause", S_CAUSE, 32'h0000_0020);
    expect_val("sys_epc", S_EPC, 32'h8000_0300);
    drain();

    // Hardware interrupt line 0 with IM2/IE enabled
    mtc0(5'd12, 32'h0000_0401); int_i = 6'b000001;
    tick(); idle();
    expect_val("im_status", S_STATUS, 32'h0040_0401);
    expect_val("int_cause10", S_CAUSE, 32'h0000_0420);
    drain();
    exc(32'h1, 32'h8000_0400, 1'b0, 32'h0);
    tick(); idle();
    expect_val("int_cause", S_CAUSE, 32'h0000_0400);
    expect_val("int_epc", S_EPC, 32'h8000_0400);
    expect_val("int_status", S_STATUS, 32'h0040_0403);
    drain();

    // Cause write mask: only IP[9:8]
    mtc0(5'd13, 32'hFFFF_FFFF);
    tick(); idle();
    expect_val("cause_wmask", S_CAUSE, 32'h0000_0700);
    drain();

    // Unknown type: flush but no update
    exc(32'h3, 32'h8000_0500, 1'b1, 32'hABCD);
    expect_val("unk_flush", S_FLUSH, 32'd1);
    expect_val("unk_newpc", S_NEWPC, 32'hBFC0_0380);
    drain();
    tick(); idle();
    expect_val("unk_status", S_STATUS, 32'h0040_0403);
    expect_val("unk_epc", S_EPC, 32'h8000_0400);
    expect_val("unk_badv", S_BADV, 32'h0000_1003);
    drain();

    // Count write and wrap
    mtc0(5'd9, 32'hFFFF_FFFF);
    tick(); idle();
    expect_val("count_write", S_COUNT, 32'hFFFF_FFFF);
    drain();
    tick(); tick();
    expect_val("count_wrap", S_COUNT, m_count);
    expect_val("count_wrap_zero", S_COUNT, 32'd0);
    drain();

    // Reset with an exception presented
    int_i = 6'd0;
    rst = 1'b1; exc(32'h8, 32'h8000_0600, 1'b1, 32'h0);
    tick(); rst = 1'b0; idle();
    expect_val("rstx_status", S_STATUS, 32'h0040_0000);
    expect_val("rstx_cause", S_CAUSE, 32'd0);
    expect_val("rstx_epc", S_EPC, 32'd0);
    expect_val("rstx_count", S_COUNT, 32'd0);
    expect_val("rstx_badv", S_BADV, 32'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
